serial_frame_tx: RTL
====================

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter BIT_TICKS, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts an even-parity bit after the data bits; 0 omits it.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to send data_in; sampled only in IDLE.
REQ-006 data_in  input  8  byte to transmit; captured on the accepting edge.
REQ-007 tx  output  1  serial line; idles high.
REQ-008 busy  output  1  high while a frame is on tx.
REQ-009 done_tick  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 The block SHALL be a Moore FSM with states IDLE, START, DATA, PARITY, STOP, plus feedback registers: tick counter t (16 bit), bit index n (3 bit) and shift register b (8 bit).
REQ-011 In IDLE with start=1 at edge E0, the block SHALL load b<=data_in, t<=0, n<=0 and enter START; with start=0 it SHALL remain in IDLE.
REQ-012 tx, busy and done_tick SHALL be registered copies of the Moore outputs, giving exactly one cycle of latency: tx falls at edge E0+1.
REQ-013 Raw Moore tx values: IDLE=1, START=0, DATA=b[0], PARITY=XOR of the captured byte, STOP=1.
REQ-014 Each bit SHALL last exactly BIT_TICKS cycles: t increments every cycle and the bit ends when t==BIT_TICKS-1; t then returns to 0.
REQ-015 START->DATA at bit end.
REQ-016 In DATA, each bit end SHALL shift b right by one and increment n; data is sent LSB first.
REQ-017 After bit n==7 ends, DATA SHALL go to PARITY if PARITY_EN=1, else to STOP; PARITY->STOP at bit end.
REQ-018 STOP->IDLE at bit end; the frame is 10 bits (PARITY_EN=0) or 11 bits (PARITY_EN=1).
REQ-019 busy SHALL be 1 from edge E0+1 until the edge at which tx completes the stop bit.
REQ-020 done_tick SHALL be 1 for exactly one cycle: the first cycle in which busy is 0 after a frame.
REQ-021 start while not in IDLE SHALL be ignored, with no effect on the frame in flight or on b.
REQ-022 A start held high or asserted during the done_tick cycle SHALL be accepted; back-to-back frames are separated by exactly one extra idle-high cycle.
REQ-023 Changes on data_in after E0 SHALL not affect the frame.

Reset
REQ-024 On reset assertion, immediately and independent of clk: state=IDLE, t=0, n=0, b=0, tx=1, busy=0, done_tick=0.
REQ-025 Reset mid-frame SHALL abandon the frame with no done_tick.
REQ-026 After reset release, the first start SHALL be honoured at the next rising edge.

Structure
REQ-027 State encodings (3 bit) and the frame bit-count constants SHALL live in a shared package/header used by the matching receiver.
REQ-028 The bit-period counter (t, clear, end-of-bit flag) SHALL be one sub-module, bit_tick_timer; everything else SHALL stay in serial_frame_tx.
REQ-029 The state register, feedback registers, next-state/output logic and output D-FFs SHALL be separate processes.

Verification
REQ-030 BIT_TICKS=4, PARITY_EN=0, data_in=0xA5, start pulse -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy high 40 cycles; done_tick one cycle after.
REQ-031 BIT_TICKS=4, PARITY_EN=1, data_in=0x07 -> parity bit 1; data_in=0xA5 -> parity bit 0; frame is 44 cycles.
REQ-032 start pulsed again at cycle 12 of a frame with data_in=0xFF -> ignored; the original byte completes unchanged.
REQ-033 start held high with data_in 0x3C then 0xC3 -> two frames; tx high for 5 cycles between them (4 stop + 1 idle).
REQ-034 reset asserted mid-DATA between clock edges -> tx=1 and busy=0 immediately; no done_tick; the next start sends a full frame.
REQ-035 BIT_TICKS=2, data_in=0x00 -> start plus 8 zero bits give tx low for 18 cycles, then 2 cycles high.

Source files
------------

// File: rtl/serial_frame_tx_pkg.sv
`default_nettype none
// ==========================================================================
// serial_frame_tx_pkg : state encodings and frame constants (shared with RX)
// Revision: 1.0
// ==========================================================================
package serial_frame_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int unsigned DATA_BITS       = 8;
  localparam int unsigned FRAME_BITS_BASE = 10;  // start + data + stop

  function automatic int unsigned frame_bits(input bit parity_en);
    return FRAME_BITS_BASE + (parity_en ? 1 : 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_tick_timer.sv
`default_nettype none
// ==========================================================================
// bit_tick_timer : bit-period counter with synchronous clear and end flag
// Revision: 1.0
// ==========================================================================
module bit_tick_timer #(
  parameter int unsigned BIT_TICKS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic end_o
);

  localparam logic [15:0] C_LAST_TICK = 16'(BIT_TICKS - 1);

  logic [15:0] t_q;
  logic [15:0] t_d;

  assign end_o = (t_q == C_LAST_TICK);

  always_comb begin
    t_d = t_q + 16'd1;
    if (clear_i || end_o) begin
      t_d = 16'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_q <= 16'd0;
    end else begin
      t_q <= t_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ==========================================================================
// serial_frame_tx : 8-bit serial frame transmitter (start, data, parity, stop)
// Revision: 1.0
// ==========================================================================
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int unsigned BIT_TICKS = 16,
  parameter bit          PARITY_EN = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       done_tick
);

  localparam logic [2:0] C_LAST_BIT = 3'(DATA_BITS - 1);

  state_t     state_q, state_d;
  logic [2:0] n_q, n_d;
  logic [7:0] b_q, b_d;
  logic       p_q, p_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       timer_clr;
  logic       bit_end;

  bit_tick_timer #(
    .BIT_TICKS (BIT_TICKS)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (timer_clr),
    .end_o   (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    b_d       = b_q;
    p_d       = p_q;
    tx_d      = 1'b1;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    timer_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d    = 1'b0;
        timer_clr = 1'b1;
        // busy_q still high here means the previous cycle closed a frame
        done_d    = busy_q;
        if (start) begin
          state_d = ST_START;
          b_d     = data_in;
          n_d     = 3'd0;
          p_d     = ^data_in;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        tx_d = b_q[0];
        if (bit_end) begin
          b_d = b_q >> 1;
          n_d = n_q + 3'd1;
          if (n_q == C_LAST_BIT) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        tx_d = p_q;
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q <= 3'd0;
      b_q <= 8'd0;
      p_q <= 1'b0;
    end else begin
      n_q <= n_d;
      b_q <= b_d;
      p_q <= p_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done_tick = done_q;

endmodule
`default_nettype wire
